// File: rtl/dma_engine.sv
// Word-granular DMA engine moving 32-bit words between data memory and one of NUM_PIM PIM units.
// One word is in flight at a time; o_dma_busy stalls the core pipeline for the whole transfer.
module dma_engine #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_PIM = 4,
  parameter int unsigned PIM_AW  = 11
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_dma_en,
  input  logic [2:0]         i_dma_funct3,
  input  logic [NUM_PIM-1:0] i_dma_sel_pim,
  input  logic [12:0]        i_dma_size,
  input  logic [XLEN-1:0]    i_dma_mem_addr,
  output logic               o_dma_busy,
  output logic               o_dma_done,
  output logic               o_dma_err,
  output logic               o_mem_req,
  input  logic               i_mem_gnt,
  output logic [XLEN-1:0]    o_mem_addr,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [3:0]         o_mem_size,
  output logic [XLEN-1:0]    o_mem_wr_data,
  input  logic [XLEN-1:0]    i_mem_rd_data,
  output logic [NUM_PIM-1:0] o_pim_sel,
  output logic               o_pim_valid,
  input  logic               i_pim_ready,
  output logic               o_pim_we,
  output logic [PIM_AW-1:0]  o_pim_addr,
  output logic [XLEN-1:0]    o_pim_wdata,
  input  logic [XLEN-1:0]    i_pim_rdata,
  input  logic               i_pim_rvalid
);

  localparam int unsigned CNT_W    = 14;
  localparam logic [2:0]  F3_LOAD  = 3'b000;
  localparam logic [2:0]  F3_STORE = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_RD,
    S_MEM_RDATA,
    S_PIM_WR,
    S_PIM_RD,
    S_PIM_RWAIT,
    S_MEM_WR
  } state_e;

  state_e             state_q;
  logic               is_load_q;
  logic [NUM_PIM-1:0] sel_q;
  logic [XLEN-1:0]    mem_addr_q, mem_addr_d;
  logic [PIM_AW-1:0]  pim_addr_q, pim_addr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [XLEN-1:0]    buf_q;
  logic               busy_q, done_q, err_q;
  logic               mem_req_q, mem_read_q, mem_write_q;
  logic [3:0]         mem_size_q;
  logic               pim_valid_q, pim_we_q;

  logic [CNT_W-1:0]   words_c;
  logic               sel_onehot_c;
  logic               cmd_legal_c;
  logic               word_done_c;
  logic               last_word_c;
  logic               unused_c;

  // Command decode, per-word address/count advance and word-completion detect.
  always_comb begin
    words_c      = (CNT_W'(i_dma_size) + CNT_W'(3)) >> 2;
    sel_onehot_c = (i_dma_sel_pim != '0) &&
                   ((i_dma_sel_pim & (i_dma_sel_pim - NUM_PIM'(1))) == '0);
    cmd_legal_c  = ((i_dma_funct3 == F3_LOAD) || (i_dma_funct3 == F3_STORE)) &&
                   sel_onehot_c && (i_dma_size != '0);
    mem_addr_d   = mem_addr_q + XLEN'(4);
    pim_addr_d   = pim_addr_q + PIM_AW'(1);
    remaining_d  = remaining_q - CNT_W'(1);
    word_done_c  = ((state_q == S_PIM_WR) && i_pim_ready) ||
                   ((state_q == S_MEM_WR) && i_mem_gnt);
    last_word_c  = (remaining_q == CNT_W'(1));
  end

  assign unused_c = ^i_dma_mem_addr[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      sel_q       <= '0;
      mem_addr_q  <= '0;
      pim_addr_q  <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_size_q  <= '0;
      pim_valid_q <= 1'b0;
      pim_we_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_size_q <= 4'b1111;
      if (i_dma_en && (state_q != S_IDLE)) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (i_dma_en) begin
            if (cmd_legal_c) begin
              is_load_q   <= (i_dma_funct3 == F3_LOAD);
              sel_q       <= i_dma_sel_pim;
              mem_addr_q  <= {i_dma_mem_addr[XLEN-1:2], 2'b00};
              pim_addr_q  <= '0;
              remaining_q <= words_c;
              busy_q      <= 1'b1;
              if (i_dma_funct3 == F3_LOAD) begin
                state_q    <= S_MEM_RD;
                mem_req_q  <= 1'b1;
                mem_read_q <= 1'b1;
              end else begin
                state_q     <= S_PIM_RD;
                pim_valid_q <= 1'b1;
                pim_we_q    <= 1'b0;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_MEM_RD: begin
          if (i_mem_gnt) begin
            mem_req_q  <= 1'b0;
            mem_read_q <= 1'b0;
            state_q    <= S_MEM_RDATA;
          end
        end
        S_MEM_RDATA: begin
          buf_q       <= i_mem_rd_data;
          pim_valid_q <= 1'b1;
          pim_we_q    <= 1'b1;
          state_q     <= S_PIM_WR;
        end
        S_PIM_WR: begin
          if (i_pim_ready) begin
            pim_valid_q <= 1'b0;
            pim_we_q    <= 1'b0;
          end
        end
        S_PIM_RD: begin
          if (i_pim_ready) begin
            pim_valid_q <= 1'b0;
            state_q     <= S_PIM_RWAIT;
          end
        end
        S_PIM_RWAIT: begin
          if (i_pim_rvalid) begin
            buf_q       <= i_pim_rdata;
            mem_req_q   <= 1'b1;
            mem_write_q <= 1'b1;
            state_q     <= S_MEM_WR;
          end
        end
        S_MEM_WR: begin
          if (i_mem_gnt) begin
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // A finished word either ends the transfer or launches the next word's first request.
      if (word_done_c) begin
        mem_addr_q  <= mem_addr_d;
        pim_addr_q  <= pim_addr_d;
        remaining_q <= remaining_d;
        if (last_word_c) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          sel_q   <= '0;
        end else if (is_load_q) begin
          state_q    <= S_MEM_RD;
          mem_req_q  <= 1'b1;
          mem_read_q <= 1'b1;
        end else begin
          state_q     <= S_PIM_RD;
          pim_valid_q <= 1'b1;
          pim_we_q    <= 1'b0;
        end
      end
    end
  end

  assign o_dma_busy    = busy_q;
  assign o_dma_done    = done_q;
  assign o_dma_err     = err_q;
  assign o_mem_req     = mem_req_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_read    = mem_read_q;
  assign o_mem_write   = mem_write_q;
  assign o_mem_size    = mem_size_q;
  assign o_mem_wr_data = buf_q;
  assign o_pim_sel     = sel_q;
  assign o_pim_valid   = pim_valid_q;
  assign o_pim_we      = pim_we_q;
  assign o_pim_addr    = pim_addr_q;
  assign o_pim_wdata   = buf_q;

endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: a transaction-level model builds the expected mem/PIM request lists per
// command; one negedge process acts as memory/PIM responder and checks every cycle against it.
module tb_dma_engine;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_dma_en;
  logic [2:0]  i_dma_funct3;
  logic [3:0]  i_dma_sel_pim;
  logic [12:0] i_dma_size;
  logic [31:0] i_dma_mem_addr;
  logic        o_dma_busy, o_dma_done, o_dma_err;
  logic        o_mem_req, i_mem_gnt;
  logic [31:0] o_mem_addr;
  logic        o_mem_read, o_mem_write;
  logic [3:0]  o_mem_size;
  logic [31:0] o_mem_wr_data, i_mem_rd_data;
  logic [3:0]  o_pim_sel;
  logic        o_pim_valid, i_pim_ready, o_pim_we;
  logic [10:0] o_pim_addr;
  logic [31:0] o_pim_wdata, i_pim_rdata;
  logic        i_pim_rvalid;

  dma_engine dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_dma_en(i_dma_en), .i_dma_funct3(i_dma_funct3), .i_dma_sel_pim(i_dma_sel_pim),
    .i_dma_size(i_dma_size), .i_dma_mem_addr(i_dma_mem_addr),
    .o_dma_busy(o_dma_busy), .o_dma_done(o_dma_done), .o_dma_err(o_dma_err),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_addr(o_mem_addr),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_size(o_mem_size),
    .o_mem_wr_data(o_mem_wr_data), .i_mem_rd_data(i_mem_rd_data),
    .o_pim_sel(o_pim_sel), .o_pim_valid(o_pim_valid), .i_pim_ready(i_pim_ready),
    .o_pim_we(o_pim_we), .o_pim_addr(o_pim_addr), .o_pim_wdata(o_pim_wdata),
    .i_pim_rdata(i_pim_rdata), .i_pim_rvalid(i_pim_rvalid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } mem_txn_t;
  typedef struct { logic [10:0] addr; logic we; logic [31:0] data; } pim_txn_t;

  int checks = 0;
  int errors = 0;

  mem_txn_t mq[$];
  pim_txn_t pq[$];
  logic        active, last_hs, cmd_issue, cmd_eval, eval_active;
  logic [2:0]  c_f3;
  logic [3:0]  c_sel, cur_sel;
  logic [12:0] c_size;
  logic [31:0] c_addr;
  int          mem_stall, pim_stall;
  logic        rd_pend, rv_pend;
  logic [31:0] rd_val, rv_val;
  int          busy_run, last_busy, busy_total, done_cnt, err_cnt;
  logic [31:0] log_mem_addr[$];
  logic [31:0] log_mem_wdata[$];
  logic [10:0] log_pim_addr[$];
  logic [3:0]  log_pim_sel[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic void model_reset();
    mq.delete();
    pq.delete();
    active = 1'b0; last_hs = 1'b0; cmd_issue = 1'b0; cmd_eval = 1'b0; eval_active = 1'b0;
    cur_sel = '0; mem_stall = 0; pim_stall = 0;
    rd_pend = 1'b0; rv_pend = 1'b0; rd_val = '0; rv_val = '0; busy_run = 0;
    i_mem_gnt = 1'b0; i_pim_ready = 1'b0; i_pim_rvalid = 1'b0;
    i_mem_rd_data = '0; i_pim_rdata = '0;
  endfunction

  // Expected request lists of one accepted command, straight from the transfer rules.
  function automatic void accept();
    int          words;
    logic [31:0] base, a, d;
    words   = (int'(c_size) + 3) / 4;
    base    = {c_addr[31:2], 2'b00};
    cur_sel = c_sel;
    active  = 1'b1;
    for (int k = 0; k < words; k++) begin
      a = base + 32'(4 * k);
      if (c_f3 == 3'b000) begin
        d = mem_data(a);
        mq.push_back('{addr: a, wr: 1'b0, data: d});
        pq.push_back('{addr: 11'(k), we: 1'b1, data: d});
      end else begin
        d = 32'hA5A5_0000 + 32'(k);
        pq.push_back('{addr: 11'(k), we: 1'b0, data: d});
        mq.push_back('{addr: a, wr: 1'b1, data: d});
      end
    end
  endfunction

  // Responder and per-cycle checker.
  initial begin : check_proc
    logic done_exp, err_exp, legal;
    model_reset();
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        chk("rst_ctrl", 64'({o_dma_busy, o_dma_done, o_dma_err, o_mem_req, o_mem_read,
                             o_mem_write, o_mem_size, o_pim_sel, o_pim_valid, o_pim_we}), 64'd0);
        chk("rst_data", 64'(|{o_mem_addr, o_mem_wr_data, o_pim_addr, o_pim_wdata}), 64'd0);
        model_reset();
      end else begin
        done_exp = last_hs;
        if (last_hs) begin active = 1'b0; last_hs = 1'b0; end
        err_exp = 1'b0;
        if (cmd_eval) begin
          cmd_eval = 1'b0;
          legal = ((c_f3 == 3'b000) || (c_f3 == 3'b001)) && ($countones(c_sel) == 1) &&
                  (c_size != 13'd0);
          if (legal && !eval_active) accept();
          else err_exp = 1'b1;
        end
        chk("busy", 64'(o_dma_busy), 64'(active));
        chk("done", 64'(o_dma_done), 64'(done_exp));
        chk("err", 64'(o_dma_err), 64'(err_exp));
        chk("pim_sel", 64'(o_pim_sel), 64'(active ? cur_sel : 4'd0));
        if (o_dma_busy) begin busy_run++; busy_total++; end
        if (o_dma_done) begin done_cnt++; last_busy = busy_run; busy_run = 0; end
        if (o_dma_err) err_cnt++;

        i_mem_gnt     = 1'b0;
        i_pim_ready   = 1'b0;
        i_mem_rd_data = rd_pend ? rd_val : 32'hDEAD_BEEF;
        rd_pend       = 1'b0;
        i_pim_rvalid  = rv_pend;
        i_pim_rdata   = rv_pend ? rv_val : 32'hBAD0_BAD0;
        rv_pend       = 1'b0;

        if (o_mem_req) begin
          chk("mem_expected", 64'(mq.size() != 0), 64'd1);
          if (mq.size() != 0) begin
            chk("mem_addr", 64'(o_mem_addr), 64'(mq[0].addr));
            chk("mem_strobes", 64'({o_mem_read, o_mem_write, o_mem_size}),
                64'({!mq[0].wr, mq[0].wr, 4'b1111}));
            if (mq[0].wr) chk("mem_wdata", 64'(o_mem_wr_data), 64'(mq[0].data));
            if (mem_stall > 0) mem_stall--;
            else begin
              i_mem_gnt = 1'b1;
              log_mem_addr.push_back(o_mem_addr);
              if (mq[0].wr) log_mem_wdata.push_back(o_mem_wr_data);
              else begin rd_pend = 1'b1; rd_val = mem_data(o_mem_addr); end
              void'(mq.pop_front());
              if (mq.size() == 0 && pq.size() == 0) last_hs = 1'b1;
            end
          end
        end else begin
          chk("mem_strobe_idle", 64'({o_mem_read, o_mem_write}), 64'd0);
        end

        if (o_pim_valid) begin
          chk("pim_expected", 64'(pq.size() != 0), 64'd1);
          if (pq.size() != 0) begin
            chk("pim_addr", 64'(o_pim_addr), 64'(pq[0].addr));
            chk("pim_we", 64'(o_pim_we), 64'(pq[0].we));
            if (pq[0].we) chk("pim_wdata", 64'(o_pim_wdata), 64'(pq[0].data));
            if (pim_stall > 0) pim_stall--;
            else begin
              i_pim_ready = 1'b1;
              log_pim_addr.push_back(o_pim_addr);
              log_pim_sel.push_back(o_pim_sel);
              if (!pq[0].we) begin rv_pend = 1'b1; rv_val = 32'hA5A5_0000 + 32'(o_pim_addr); end
              void'(pq.pop_front());
              if (mq.size() == 0 && pq.size() == 0) last_hs = 1'b1;
            end
          end
        end else begin
          chk("pim_we_idle", 64'(o_pim_we), 64'd0);
        end

        if (cmd_issue) begin
          cmd_issue   = 1'b0;
          cmd_eval    = 1'b1;
          eval_active = active;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                       input logic [31:0] addr);
    @(posedge i_clk); #1;
    i_dma_en = 1'b1; i_dma_funct3 = f3; i_dma_sel_pim = sel; i_dma_size = size;
    i_dma_mem_addr = addr;
    c_f3 = f3; c_sel = sel; c_size = size; c_addr = addr; cmd_issue = 1'b1;
    @(posedge i_clk); #1;
    i_dma_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((active || cmd_issue || cmd_eval || last_hs) && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    chk("wait_done_timeout", 64'(n >= budget), 64'd0);
  endtask

  task automatic clear_logs();
    log_mem_addr.delete(); log_mem_wdata.delete(); log_pim_addr.delete(); log_pim_sel.delete();
    done_cnt = 0; err_cnt = 0; busy_total = 0; last_busy = 0;
  endtask

  initial begin : main_proc
    int n;
    i_rst_n = 1'b0; i_dma_en = 1'b0; i_dma_funct3 = '0; i_dma_sel_pim = '0;
    i_dma_size = '0; i_dma_mem_addr = '0;
    clear_logs();
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Plain LOAD, zero wait states.
    clear_logs();
    issue(3'b000, 4'b0010, 13'd16, 32'h1000_0008);
    wait_done(200);
    chk("t1_busy", 64'(last_busy), 64'd12);
    chk("t1_done", 64'(done_cnt), 64'd1);
    chk("t1_nrd", 64'(log_mem_addr.size()), 64'd4);
    chk("t1_a0", 64'(log_mem_addr[0]), 64'h1000_0008);
    chk("t1_a3", 64'(log_mem_addr[3]), 64'h1000_0014);
    chk("t1_p3", 64'(log_pim_addr[3]), 64'd3);
    chk("t1_sel", 64'(log_pim_sel[0]), 64'b0010);

    // STORE with unaligned address and partial last word.
    clear_logs();
    issue(3'b001, 4'b0100, 13'd5, 32'h2000_0003);
    wait_done(200);
    chk("t2_busy", 64'(last_busy), 64'd6);
    chk("t2_nwr", 64'(log_mem_addr.size()), 64'd2);
    chk("t2_a0", 64'(log_mem_addr[0]), 64'h2000_0000);
    chk("t2_a1", 64'(log_mem_addr[1]), 64'h2000_0004);
    chk("t2_d0", 64'(log_mem_wdata[0]), 64'hA5A5_0000);
    chk("t2_d1", 64'(log_mem_wdata[1]), 64'hA5A5_0001);

    // Backpressure on both sides.
    clear_logs();
    @(posedge i_clk); #1;
    mem_stall = 3; pim_stall = 2;
    issue(3'b000, 4'b0001, 13'd8, 32'h3000_0010);
    wait_done(200);
    chk("t3_busy", 64'(last_busy), 64'd11);
    chk("t3_done", 64'(done_cnt), 64'd1);

    // Illegal commands.
    clear_logs();
    issue(3'b010, 4'b0001, 13'd8, 32'h0000_0100); wait_done(50);
    issue(3'b000, 4'b0011, 13'd8, 32'h0000_0100); wait_done(50);
    issue(3'b001, 4'b1000, 13'd0, 32'h0000_0100); wait_done(50);
    issue(3'b000, 4'b0000, 13'd4, 32'h0000_0100); wait_done(50);
    chk("t4_err", 64'(err_cnt), 64'd4);
    chk("t4_busy", 64'(busy_total), 64'd0);
    chk("t4_traffic", 64'(log_mem_addr.size() + log_pim_addr.size()), 64'd0);

    // Address wrap.
    clear_logs();
    issue(3'b000, 4'b1000, 13'd8, 32'hFFFF_FFFC);
    wait_done(200);
    chk("t5_a0", 64'(log_mem_addr[0]), 64'hFFFF_FFFC);
    chk("t5_a1", 64'(log_mem_addr[1]), 64'h0000_0000);
    chk("t5_busy", 64'(last_busy), 64'd6);

    // Command while busy is flagged and ignored.
    clear_logs();
    issue(3'b000, 4'b1000, 13'd12, 32'h4000_0000);
    issue(3'b001, 4'b0001, 13'd4, 32'h0000_0000);
    wait_done(200);
    chk("t6_err", 64'(err_cnt), 64'd1);
    chk("t6_busy", 64'(last_busy), 64'd9);
    chk("t6_nrd", 64'(log_mem_addr.size()), 64'd3);

    // Largest transfer: 8191 bytes -> 2048 words.
    clear_logs();
    issue(3'b000, 4'b0100, 13'h1FFF, 32'h5000_0000);
    wait_done(7000);
    chk("t7_busy", 64'(last_busy), 64'd6144);
    chk("t7_nrd", 64'(log_mem_addr.size()), 64'd2048);
    chk("t7_alast", 64'(log_mem_addr[2047]), 64'h5000_1FFC);
    chk("t7_plast", 64'(log_pim_addr[2047]), 64'h7FF);

    // Reset in the middle of a STORE, then a normal LOAD.
    clear_logs();
    issue(3'b001, 4'b0010, 13'd12, 32'h6000_0000);
    n = 0;
    while (log_mem_addr.size() < 1 && n < 50) begin @(posedge i_clk); n++; end
    chk("t8_word1_timeout", 64'(n >= 50), 64'd0);
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    chk("t8_rst_busy", 64'({o_dma_busy, o_mem_req, o_pim_valid, o_pim_sel}), 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("t8_nodone", 64'(done_cnt), 64'd0);
    clear_logs();
    issue(3'b000, 4'b0001, 13'd4, 32'h7000_0004);
    wait_done(100);
    chk("t8_busy", 64'(last_busy), 64'd3);
    chk("t8_done", 64'(done_cnt), 64'd1);
    chk("t8_a0", 64'(log_mem_addr[0]), 64'h7000_0004);

    repeat (3) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
Name: dma_engine

Overview:
- Word-granular DMA engine directly downstream of the core's EX-stage DMA command port.
- Consumes the one-cycle DMA command (enable, funct3, PIM select, byte size, memory address).
- Moves data between data memory and one of four PIM units, one 32-bit word at a time.
- Drives the busy flag the core uses to stall its pipeline.

Parameters:
XLEN, 32, data/address width of the memory side.
NUM_PIM, 4, number of PIM units (width of the select vector).
PIM_AW, 11, PIM word-address width; must cover 2048 words.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_dma_en  in  1  command strobe, one cycle
i_dma_funct3  in  3  000 = LOAD (mem->PIM), 001 = STORE (PIM->mem), others illegal
i_dma_sel_pim  in  NUM_PIM  one-hot PIM select
i_dma_size  in  13  transfer length in bytes
i_dma_mem_addr  in  XLEN  memory start byte address
o_dma_busy  out  1  transfer in progress
o_dma_done  out  1  one-cycle completion pulse
o_dma_err  out  1  one-cycle illegal-command pulse
o_mem_req  out  1  memory request
i_mem_gnt  in  1  memory grant
o_mem_addr  out  XLEN  word-aligned memory address
o_mem_read  out  1  read strobe
o_mem_write  out  1  write strobe
o_mem_size  out  4  byte enables, always 4'b1111
o_mem_wr_data  out  XLEN  write data
i_mem_rd_data  in  XLEN  read data, valid the cycle after a granted read
o_pim_sel  out  NUM_PIM  latched PIM select
o_pim_valid  out  1  PIM request valid
i_pim_ready  in  1  PIM accepts request
o_pim_we  out  1  1 = write, 0 = read
o_pim_addr  out  PIM_AW  PIM word address
o_pim_wdata  out  XLEN  PIM write data
i_pim_rdata  in  XLEN  PIM read data
i_pim_rvalid  in  1  PIM read data valid

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; counters and buffer cleared.
- Reset asserted mid-transfer aborts immediately. Outstanding mem/PIM requests are dropped; no done pulse is issued.
- Command acceptance, only in IDLE with i_dma_en = 1:
  - Latch funct3, sel_pim, and mem_addr with bits [1:0] forced to 0.
  - Word count = (size + 3) >> 2, computed in 14-bit arithmetic (max 2048).
  - PIM address starts at 0.
- Rejected commands (no transfer, o_dma_err pulses the next cycle, o_dma_busy stays 0):
  - funct3 not 000/001.
  - sel_pim not one-hot.
  - size == 0.
- i_dma_en while not IDLE: ignored and o_dma_err pulses. The core cannot issue this, but the bench checks it.
- o_dma_busy = (state != IDLE). It rises the cycle after an accepted i_dma_en.
- LOAD loop, per word:
  - MEM_RD: o_mem_req = o_mem_read = 1 and o_mem_addr = current address, held until i_mem_gnt.
  - MEM_RDATA: capture i_mem_rd_data into the word buffer.
  - PIM_WR: o_pim_valid = o_pim_we = 1, buffer on o_pim_wdata, held until i_pim_ready.
- STORE loop, per word:
  - PIM_RD: o_pim_valid = 1, o_pim_we = 0, held until i_pim_ready.
  - PIM_RWAIT: wait for i_pim_rvalid, earliest the cycle after acceptance; capture i_pim_rdata.
  - MEM_WR: o_mem_req = o_mem_write = 1 with buffer on o_mem_wr_data, held until i_mem_gnt.
- After each completed word: memory address += 4 (wraps mod 2^XLEN), PIM address += 1, remaining count -= 1.
- When remaining count reaches 0: go to IDLE. o_dma_done pulses and o_dma_busy = 0 in that same cycle.
- Zero wait-state throughput: 3 cycles/word in both directions; busy high for exactly 3N cycles.
- Request outputs (address, data, strobes) stay stable while a request is held waiting for gnt/ready.
- o_pim_sel holds the latched select during busy and is 0 in IDLE.

Test Plan:
- LOAD, size = 16, addr = 0x1000_0008, sel = 0010, gnt/ready tied 1 -> mem reads 0x..08, 0x..0C, 0x..10, 0x..14; PIM writes to addr 0..3 on unit 1 with the same data; busy high 12 cycles; done pulse once.
- STORE, size = 5, addr = 0x2000_0003, PIM returns 0xA5A5_0000 + addr, rvalid 1 cycle after ready -> 2 words written to 0x2000_0000 and 0x2000_0004, data 0xA5A5_0000 and 0xA5A5_0001, size 4'b1111.
- Backpressure: LOAD size = 8 with gnt withheld 3 cycles and ready withheld 2 cycles -> req/valid and addr/data held stable; busy = 6 + 5 = 11 cycles.
- Illegal commands: funct3 = 3'b010; sel = 0011; size = 0 -> each gives an err pulse the next cycle, busy stays 0, no mem/PIM traffic.
- Address wrap: LOAD size = 8, addr = 0xFFFF_FFFC -> reads 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-STORE after word 1 -> all outputs 0 the same cycle; a following LOAD size = 4 completes normally.
